oam_dma_arbiter: RTL and testbench
==================================

// Module: oam_dma_arbiter
// PURPOSE
//  Sprite (OAM) DMA engine and system-bus arbiter for the 2A03 core. A CPU write of page P to DMA_REG_ADDR
//  halts the CPU and copies XFER_LEN bytes from $PP00.. to OAM_DATA_ADDR, one read/write pair per byte.
//  Sits between control/datapath bus outputs and memory; owns the bus mux and the CPU ready line.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  trigger register address
//  OAM_DATA_ADDR  16'h2004  destination address written for every byte
//  XFER_LEN       256       bytes per transfer; power of two, 2..256
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active-low
//  cpu_addr     in   16  CPU address
//  cpu_dout     in   8   CPU write data
//  cpu_rw       in   1   CPU direction, 1=read 0=write (same sense as mem_rw)
//  cpu_rdy      out  1   0 = CPU must hold its current state
//  bus_addr     out  16  memory address
//  bus_dout     out  8   memory write data
//  bus_rw       out  1   memory direction, 1=read
//  bus_din      in   8   memory read data, valid at end of read cycle
//  dma_busy     out  1   1 from HALT through last WRITE
//  dma_done     out  1   (DMA_DONE_PULSE_EN only) one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async): state=IDLE, page=0, idx=0, data=0, phase=0, cpu_rdy=1, dma_busy=0, dma_done=0;
//    bus follows CPU. Reset mid-transfer aborts at once; no further DMA bus cycles; CPU released.
//  - phase: free-running 1-bit toggle every clk from reset (APU get/put parity).
//  - States: IDLE -> HALT -> [ALIGN] -> READ <-> WRITE -> IDLE.
//  - IDLE: cpu_rdy=1. If cpu_rw=0 && cpu_addr==DMA_REG_ADDR: page<=cpu_dout, idx<=0, next=HALT.
//    Any other address (e.g. $4015) is ignored.
//  - HALT: cpu_rdy=0, dma_busy=1, bus follows CPU. CPU write cycles are not stoppable: while cpu_rw=0
//    stay in HALT. On first cycle with cpu_rw=1 (halt/dummy read): next=READ if phase==1, else ALIGN.
//  - ALIGN: one cycle, cpu_rdy=0, bus_addr=cpu_addr, bus_rw=1; next=READ. READ always lands on phase 0.
//  - READ: bus_addr={page,idx}, bus_rw=1; data<=bus_din at clk edge; next=WRITE.
//  - WRITE: bus_addr=OAM_DATA_ADDR, bus_dout=data, bus_rw=0. If idx==XFER_LEN-1 next=IDLE, else
//    idx<=idx+1 (8-bit, no carry into page), next=READ.
//  - cpu_rdy=1 again the cycle after the last WRITE. Total halt = 1 + {0,1} + 2*XFER_LEN cycles
//    (513 or 514 at default), plus any extra HALT cycles spent waiting on CPU writes.
//  - Writes to DMA_REG_ADDR while not IDLE are ignored; a write on the first IDLE cycle after completion
//    starts a new transfer normally.
//  - Bus mux is combinational from state; in IDLE/HALT bus_addr/bus_dout/bus_rw = cpu_addr/cpu_dout/cpu_rw.
// CONFIGURATION
//  DMA_DONE_PULSE_EN defined: dma_done=1 for exactly the cycle after the final WRITE (first IDLE cycle),
//    0 otherwise; not asserted on reset abort.
//  Not defined: dma_done port absent; all other behaviour identical.
// TESTING
//  1 Reset then idle 10 cycles -> cpu_rdy=1, dma_busy=0, bus_addr tracks cpu_addr each cycle.
//  2 Write $02 to $4014, halt cycle on phase 1 -> reads $0200..$02FF; 256 writes to $2004 with
//    matching data (mem[$02nn]=nn^$A5); cpu_rdy low exactly 513 cycles.
//  3 Same trigger, halt cycle on phase 0 -> one ALIGN cycle, cpu_rdy low 514 cycles; first READ on phase 0.
//  4 Trigger followed by two CPU write cycles, then read -> 2 extra HALT cycles, both CPU writes reach bus.
//  5 Assert rst_n=0 when idx=$80 during WRITE -> same cycle: cpu_rdy=1, bus follows CPU; no later $2004 writes.
//  6 Write to $4015, and to $4014 during busy -> no new transfer; with DMA_DONE_PULSE_EN, test 2 gives one
//    dma_done pulse on the cycle cpu_rdy rises.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
//   Sprite (OAM) DMA engine and system-bus arbiter for the 2A03 core.
//   A CPU write of page P to DMA_REG_ADDR halts the CPU and copies XFER_LEN
//   bytes from $PP00.. to OAM_DATA_ADDR as one read/write pair per byte.
//   The block owns the memory-bus mux and the CPU ready line.
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   cpu_addr/dout/rw   CPU bus request (rw: 1=read, 0=write)
//   cpu_rdy            0 = CPU must hold its current state
//   bus_addr/dout/rw   memory bus (muxed CPU / DMA)
//   bus_din            memory read data, valid at end of read cycle
//   dma_busy           1 from HALT through the last WRITE
//   dma_done           one-cycle completion pulse (only with DMA_DONE_PULSE_EN)
//
// Build option
//   DMA_DONE_PULSE_EN  adds the dma_done output.
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_rw,
  input  logic [7:0]  bus_din,
  output logic        dma_busy
`ifdef DMA_DONE_PULSE_EN
  ,
  output logic        dma_done
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      phase_q <= phase_d;
    end
  end

  // APU get/put parity; the DMA read must land on phase 0.
  assign phase_d = ~phase_q;

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cpu_rdy  = 1'b0;
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_rw   = cpu_rw;
    unique case (state_q)
      IDLE: begin
        cpu_rdy = 1'b1;
        if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
          page_d  = cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // CPU write cycles cannot be stalled; wait for the first read cycle.
        // Halting on phase 1 puts the next cycle on phase 0, else align once.
        if (cpu_rw) state_d = phase_q ? READ : ALIGN;
      end
      ALIGN: begin
        bus_rw  = 1'b1;
        state_d = READ;
      end
      READ: begin
        bus_addr = {page_q, idx_q};
        bus_rw   = 1'b1;
        data_d   = bus_din;
        state_d  = WRITE;
      end
      WRITE: begin
        bus_addr = OAM_DATA_ADDR;
        bus_dout = data_q;
        bus_rw   = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;   // wraps within the page, never into it
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_busy = (state_q != IDLE);

`ifdef DMA_DONE_PULSE_EN
  logic done_q, done_d;

  // High for the first IDLE cycle after the final WRITE only.
  assign done_d = (state_q == WRITE) && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign dma_done = done_q;
`endif

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_arbiter
//   Scoreboard bench for oam_dma_arbiter. Expected DMA reads and $2004 write
//   data are queued when a transfer is triggered and popped by a negedge
//   monitor as the bus produces them. Memory model: mem[a] = a[7:0] ^ $A5.
//   Build with DMA_DONE_PULSE_EN to also exercise dma_done.
// ---------------------------------------------------------------------------
module tb_oam_dma_arbiter;

  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_REG = 16'h2004;
  localparam int          XFER    = 256;

  logic        clk, rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rw;
  logic [7:0]  bus_din;
  logic        dma_busy;
`ifdef DMA_DONE_PULSE_EN
  logic        dma_done;
`endif

  oam_dma_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_rw   (cpu_rw),
    .cpu_rdy  (cpu_rdy),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_rw   (bus_rw),
    .bus_din  (bus_din),
    .dma_busy (dma_busy)
`ifdef DMA_DONE_PULSE_EN
    ,
    .dma_done (dma_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_din = bus_addr[7:0] ^ 8'hA5;

  int checks = 0;
  int errors = 0;
  int rdy_low = 0;
  logic tb_phase;
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_wr[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference parity: cleared by reset, toggles on every clock afterwards.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_phase <= 1'b0;
    else        tb_phase <= ~tb_phase;

  // Bus monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!cpu_rdy) rdy_low++;
`ifdef DMA_DONE_PULSE_EN
      if (dma_busy) chk("done_while_busy", dma_done, 1'b0);
`endif
      if (!dma_busy) begin
        chk("idle_rdy", cpu_rdy, 1'b1);
        chk("idle_addr", bus_addr, cpu_addr);
        chk("idle_rw", bus_rw, cpu_rw);
        chk("idle_dout", bus_dout, cpu_dout);
      end else if (!bus_rw && bus_addr == OAM_REG) begin
        if (exp_wr.size() == 0) chk("unexpected_oam_wr", 1, 0);
        else chk("oam_wr_data", bus_dout, exp_wr.pop_front());
      end else if (bus_rw && bus_addr != cpu_addr) begin
        if (exp_rd.size() == 0) chk("unexpected_dma_rd", 1, 0);
        else chk("dma_rd_addr", bus_addr, exp_rd.pop_front());
        chk("dma_rd_phase", tb_phase, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_idle();
    cpu_addr = 16'h8001; cpu_rw = 1'b1; cpu_dout = 8'h00;
  endtask

  task automatic queue_xfer(input logic [7:0] page);
    for (int i = 0; i < XFER; i++) begin
      exp_rd.push_back({page, 8'(i)});
      exp_wr.push_back(8'(i) ^ 8'hA5);
    end
  endtask

  // want_ph: phase of the cycle in which the halt (first CPU read) is seen.
  task automatic run_xfer(input logic [7:0] page, input logic want_ph,
                          input int n_extra, input bit inj);
    logic dec_ph;
    bit   fin;
    int   exp_low;
    logic target;
    fin = 1'b0;
    target = want_ph ^ 1'((n_extra + 1) % 2);
    step();
    for (int k = 0; k < 2; k++) if (tb_phase != target) step();
    queue_xfer(page);
    rdy_low = 0;
    cpu_addr = DMA_REG; cpu_rw = 1'b0; cpu_dout = page;
    step();
    for (int e = 0; e < n_extra; e++) begin
      cpu_addr = 16'h0300 + 16'(e); cpu_rw = 1'b0; cpu_dout = 8'(e + 1);
      @(negedge clk);
      chk("halt_wr_addr", bus_addr, cpu_addr);
      chk("halt_wr_rw", bus_rw, 1'b0);
      chk("halt_wr_dout", bus_dout, cpu_dout);
      chk("halt_rdy", cpu_rdy, 1'b0);
      step();
    end
    cpu_idle();
    dec_ph = tb_phase;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (!dma_busy) begin fin = 1'b1; break; end
      @(posedge clk); #1;
      if (inj && c == 20) begin
        cpu_addr = DMA_REG; cpu_rw = 1'b0; cpu_dout = 8'h05;
      end else cpu_idle();
    end
    if (!fin) chk("xfer_timeout", 0, 1);
    exp_low = 1 + n_extra + (dec_ph ? 0 : 1) + 2 * XFER;
    chk("rdy_low_cycles", rdy_low, exp_low);
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
`ifdef DMA_DONE_PULSE_EN
    chk("done_pulse", dma_done, 1'b1);
    @(negedge clk);
    chk("done_clear", dma_done, 1'b0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_n = 1'b0;
    cpu_idle();
    #2;
    chk("rst_rdy", cpu_rdy, 1'b1);
    chk("rst_busy", dma_busy, 1'b0);
    chk("rst_bus_addr", bus_addr, cpu_addr);
`ifdef DMA_DONE_PULSE_EN
    chk("rst_done", dma_done, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // 1: idle, bus tracks the CPU (monitor checks every cycle).
    for (int i = 0; i < 10; i++) begin
      step();
      cpu_addr = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      cpu_rw   = 1'b1;
      cpu_dout = 8'($urandom);
    end

    // 2: halt seen on phase 1 -> 513 cycles.
    run_xfer(8'h02, 1'b1, 0, 1'b0);
    // 3: halt seen on phase 0 -> ALIGN, 514 cycles.
    run_xfer(8'h02, 1'b0, 0, 1'b0);
    // 4: two CPU writes stall the halt.
    run_xfer(8'h03, 1'b1, 2, 1'b0);

    // 6: $4015 ignored; $4014 during busy ignored.
    step();
    cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h07;
    step();
    cpu_idle();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("w4015_busy", dma_busy, 1'b0);
    end
    run_xfer(8'h04, 1'b1, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_inj_busy", dma_busy, 1'b0);
    end

    // 5: reset during the WRITE of idx $80.
    queue_xfer(8'h02);
    cpu_addr = DMA_REG; cpu_rw = 1'b0; cpu_dout = 8'h02;
    step();
    cpu_idle();
    hit = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!bus_rw && bus_addr == OAM_REG && bus_dout == (8'h80 ^ 8'hA5)) begin
        hit = 1'b1; break;
      end
    end
    if (!hit) chk("abort_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdy", cpu_rdy, 1'b1);
    chk("abort_busy", dma_busy, 1'b0);
    chk("abort_bus_addr", bus_addr, cpu_addr);
    chk("abort_bus_rw", bus_rw, cpu_rw);
`ifdef DMA_DONE_PULSE_EN
    chk("abort_done", dma_done, 1'b0);
`endif
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_abort_busy", dma_busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
